// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
//  mem_arbiter_pkg -- shared types and constants for the two-port memory arbiter
//  Revision: 1.0
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam logic [1:0] IO_PREFIX_DEFAULT = 2'b11;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_decode.sv
// ============================================================================
//  mem_io_decode -- flags addresses whose top two bits select I/O space
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mem_io_decode
  import mem_arbiter_pkg::*;
#(
  parameter int         ADDR_W    = 16,
  parameter logic [1:0] IO_PREFIX = IO_PREFIX_DEFAULT
) (
  input  logic [ADDR_W-1:0] adr_i,
  output logic              is_io_o
);

  assign is_io_o = ((adr_i >> (ADDR_W - 2)) == ADDR_W'(IO_PREFIX));

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
//  mem_arbiter -- round-robin arbiter granting a CPU and a DMA port access to a
//  shared memory / I/O bus through a four-state, fully registered sequencer.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int         ADDR_W    = 16,
  parameter int         DATA_W    = 16,
  parameter logic [1:0] IO_PREFIX = IO_PREFIX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_adr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_adr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_en,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              io_read,
  output logic              io_write,
  input  logic [DATA_W-1:0] io_rdata,
  output logic              busy
);

  state_t              state_q;
  logic                port_q;
  logic                last_q;
  logic                we_q;
  logic                is_io_q;
  logic [ADDR_W-1:0]   adr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   c_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic                c_done_q;
  logic                d_done_q;
  logic                mem_en_q;
  logic                mem_read_q;
  logic                mem_write_q;
  logic                io_read_q;
  logic                io_write_q;
  logic                busy_q;

  logic                grant_d;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_adr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_is_io;

  // On a tie the port that did not win last time is served.
  always_comb begin
    grant_d = PORT_C;
    if (c_req && d_req) begin
      grant_d = ~last_q;
    end else if (d_req) begin
      grant_d = PORT_D;
    end
  end

  assign sel_we    = (grant_d == PORT_D) ? d_we    : c_we;
  assign sel_adr   = (grant_d == PORT_D) ? d_adr   : c_adr;
  assign sel_wdata = (grant_d == PORT_D) ? d_wdata : c_wdata;

  mem_io_decode #(
    .ADDR_W    (ADDR_W),
    .IO_PREFIX (IO_PREFIX)
  ) u_decode (
    .adr_i   (sel_adr),
    .is_io_o (sel_is_io)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      port_q      <= PORT_C;
      last_q      <= PORT_D;
      we_q        <= 1'b0;
      is_io_q     <= 1'b0;
      adr_q       <= '0;
      wdata_q     <= '0;
      c_rdata_q   <= '0;
      d_rdata_q   <= '0;
      c_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      io_read_q   <= 1'b0;
      io_write_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // Strobes and done are single-cycle pulses; default them low.
      c_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      io_read_q   <= 1'b0;
      io_write_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (c_req || d_req) begin
            port_q  <= grant_d;
            last_q  <= grant_d;
            we_q    <= sel_we;
            is_io_q <= sel_is_io;
            adr_q   <= sel_adr;
            wdata_q <= sel_wdata;
            busy_q  <= 1'b1;
            state_q <= ST_ACCESS;
            if (sel_is_io) begin
              io_read_q  <= ~sel_we;
              io_write_q <= sel_we;
            end else begin
              mem_en_q    <= 1'b1;
              mem_read_q  <= ~sel_we;
              mem_write_q <= sel_we;
            end
          end
        end
        ST_ACCESS: begin
          state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (!we_q) begin
            if (port_q == PORT_C) begin
              c_rdata_q <= is_io_q ? io_rdata : mem_rdata;
            end else begin
              d_rdata_q <= is_io_q ? io_rdata : mem_rdata;
            end
          end
          c_done_q <= (port_q == PORT_C);
          d_done_q <= (port_q == PORT_D);
          state_q  <= ST_DONE;
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign c_rdata   = c_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign c_done    = c_done_q;
  assign d_done    = d_done_q;
  assign mem_en    = mem_en_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_adr   = adr_q;
  assign mem_wdata = wdata_q;
  assign io_read   = io_read_q;
  assign io_write  = io_write_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
//  tb_mem_arbiter -- scenario tasks with inline checks plus a done-driven
//  scoreboard that compares the completing port and its read data.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  typedef struct {
    logic        port;
    logic [15:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, d_req, d_we;
  logic [15:0] c_adr, c_wdata, d_adr, d_wdata;
  logic [15:0] c_rdata, d_rdata;
  logic        c_done, d_done;
  logic        mem_en, mem_read, mem_write, io_read, io_write, busy;
  logic [15:0] mem_adr, mem_wdata, mem_rdata, io_rdata;
  logic        rd_model;
  logic [15:0] mem_rdata_r;

  int          total = 0;
  int          bad   = 0;
  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [15:0] model_rdata [2];

  always #5 clk = ~clk;

  // Memory returns a value derived from the address; I/O uses a different key.
  assign mem_rdata = rd_model ? (mem_adr ^ 16'h5A5A) : mem_rdata_r;
  assign io_rdata  = mem_adr ^ 16'h3C3C;

  mem_arbiter #(
    .ADDR_W    (16),
    .DATA_W    (16),
    .IO_PREFIX (2'b11)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .c_req     (c_req),
    .c_we      (c_we),
    .c_adr     (c_adr),
    .c_wdata   (c_wdata),
    .c_rdata   (c_rdata),
    .c_done    (c_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_adr     (d_adr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .mem_en    (mem_en),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_adr   (mem_adr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .io_read   (io_read),
    .io_write  (io_write),
    .io_rdata  (io_rdata),
    .busy      (busy)
  );

  always @(posedge clk) begin
    #1;
    if (!rst && (c_done || d_done)) begin
      total++;
      if (c_done && d_done) begin
        bad++;
        $display("FAIL sb_both_done: c_done=%b d_done=%b, need only one", c_done, d_done);
      end else if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_done: c_done=%b d_done=%b with nothing outstanding", c_done, d_done);
      end else begin
        mon_e = sb_q.pop_front();
        if (d_done !== mon_e.port || (d_done ? d_rdata : c_rdata) !== mon_e.rdata) begin
          bad++;
          $display("FAIL sb_done: port=%0d rdata=%h, need port=%0d rdata=%h",
                   d_done, d_done ? d_rdata : c_rdata, mon_e.port, mon_e.rdata);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic port, input logic we, input logic [15:0] rd);
    if (!we) model_rdata[port] = rd;
    sb_q.push_back('{port: port, rdata: model_rdata[port]});
  endtask

  task automatic do_reset;
    rst = 1'b1;
    sb_q.delete();
    model_rdata[0] = 16'h0;
    model_rdata[1] = 16'h0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    c_req = 0; c_we = 0; c_adr = 0; c_wdata = 0;
    d_req = 0; d_we = 0; d_adr = 0; d_wdata = 0;
    rd_model = 0; mem_rdata_r = 0;
    model_rdata[0] = 16'h0;
    model_rdata[1] = 16'h0;
    tick();
    tick();
    total++;
    if ({mem_en, mem_read, mem_write, io_read, io_write} !== 5'b0) begin
      bad++;
      $display("FAIL reset_strobes: got %b, need 00000", {mem_en, mem_read, mem_write, io_read, io_write});
    end
    total++;
    if ({busy, c_done, d_done} !== 3'b0) begin
      bad++;
      $display("FAIL reset_busy_done: got %b, need 000", {busy, c_done, d_done});
    end
    total++;
    if ({c_rdata, d_rdata, mem_adr, mem_wdata} !== 64'h0) begin
      bad++;
      $display("FAIL reset_regs: got %h %h %h %h, need zeros", c_rdata, d_rdata, mem_adr, mem_wdata);
    end
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_mem_read;
    rd_model = 0; mem_rdata_r = 16'hBEEF;
    c_req = 1; c_we = 0; c_adr = 16'h0010;
    push(1'b0, 1'b0, 16'hBEEF);
    tick();
    total++;
    if ({mem_read, mem_en, mem_write, io_read, io_write, busy} !== 6'b110001 || mem_adr !== 16'h0010) begin
      bad++;
      $display("FAIL read_access: strobes=%b adr=%h, need 110001 adr=0010",
               {mem_read, mem_en, mem_write, io_read, io_write, busy}, mem_adr);
    end
    tick();
    total++;
    if ({mem_read, mem_en, c_done} !== 3'b0 || mem_adr !== 16'h0010) begin
      bad++;
      $display("FAIL read_capture: rd/en/done=%b adr=%h, need 000 adr=0010", {mem_read, mem_en, c_done}, mem_adr);
    end
    tick();
    total++;
    if (c_done !== 1'b1 || d_done !== 1'b0 || c_rdata !== 16'hBEEF) begin
      bad++;
      $display("FAIL read_done: c_done=%b d_done=%b c_rdata=%h, need 1 0 beef", c_done, d_done, c_rdata);
    end
    c_req = 0;
    tick();
    total++;
    if ({c_done, busy} !== 2'b0) begin
      bad++;
      $display("FAIL read_idle: done/busy=%b, need 00", {c_done, busy});
    end
  endtask

  task automatic test_io_write;
    d_req = 1; d_we = 1; d_adr = 16'hC004; d_wdata = 16'h1234;
    push(1'b1, 1'b1, 16'h0);
    tick();
    total++;
    if ({io_write, io_read, mem_en, mem_write, mem_read} !== 5'b10000 ||
        mem_adr !== 16'hC004 || mem_wdata !== 16'h1234) begin
      bad++;
      $display("FAIL io_access: strobes=%b adr=%h wdata=%h, need 10000 c004 1234",
               {io_write, io_read, mem_en, mem_write, mem_read}, mem_adr, mem_wdata);
    end
    tick();
    total++;
    if (io_write !== 1'b0 || mem_adr !== 16'hC004 || mem_wdata !== 16'h1234) begin
      bad++;
      $display("FAIL io_capture: io_write=%b adr=%h wdata=%h, need 0 c004 1234", io_write, mem_adr, mem_wdata);
    end
    tick();
    total++;
    if (d_done !== 1'b1 || c_done !== 1'b0 || c_rdata !== 16'hBEEF) begin
      bad++;
      $display("FAIL io_done: d_done=%b c_done=%b c_rdata=%h, need 1 0 beef", d_done, c_done, c_rdata);
    end
    d_req = 0;
    tick();
  endtask

  task automatic test_round_robin;
    int ndone = 0;
    int t [4];
    do_reset();
    rd_model = 1;
    c_req = 1; c_we = 0; c_adr = 16'h0100;
    d_req = 1; d_we = 0; d_adr = 16'h0200;
    push(1'b0, 1'b0, 16'h0100 ^ 16'h5A5A);
    push(1'b1, 1'b0, 16'h0200 ^ 16'h5A5A);
    push(1'b0, 1'b0, 16'h0100 ^ 16'h5A5A);
    push(1'b1, 1'b0, 16'h0200 ^ 16'h5A5A);
    for (int i = 0; i < 30 && ndone < 4; i++) begin
      tick();
      if (c_done || d_done) begin
        t[ndone] = i;
        ndone++;
        if (ndone == 4) begin
          c_req = 0;
          d_req = 0;
        end
      end
    end
    c_req = 0; d_req = 0;
    total++;
    if (ndone != 4) begin
      bad++;
      $display("FAIL rr_count: got %0d dones, need 4", ndone);
    end else begin
      total++;
      if (t[0] != 2 || t[1] - t[0] != 4 || t[2] - t[1] != 4 || t[3] - t[2] != 4) begin
        bad++;
        $display("FAIL rr_spacing: done cycles %0d %0d %0d %0d, need 2 6 10 14", t[0], t[1], t[2], t[3]);
      end
    end
    tick();
    tick();
  endtask

  task automatic test_pulse;
    int nc = 0;
    int nd = 0;
    rd_model = 1;
    c_req = 1; c_we = 0; c_adr = 16'h0300;
    push(1'b0, 1'b0, 16'h0300 ^ 16'h5A5A);
    tick();
    c_req = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (c_done) nc++;
      if (d_done) nd++;
    end
    total++;
    if (nc != 1 || nd != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL pulse_req: c_done=%0d d_done=%0d busy=%b, need 1 0 0", nc, nd, busy);
    end
  endtask

  task automatic test_reset_mid;
    int nd = 0;
    rd_model = 1;
    c_req = 1; c_we = 0; c_adr = 16'h0400;
    tick();
    total++;
    if (mem_read !== 1'b1) begin
      bad++;
      $display("FAIL rmid_access: mem_read=%b, need 1", mem_read);
    end
    c_req = 0;
    #2 rst = 1'b1;
    model_rdata[0] = 16'h0;
    model_rdata[1] = 16'h0;
    #1;
    total++;
    if ({mem_read, mem_en, mem_write, io_read, io_write, busy, c_done} !== 7'b0) begin
      bad++;
      $display("FAIL rmid_async: outs=%b, need 0000000",
               {mem_read, mem_en, mem_write, io_read, io_write, busy, c_done});
    end
    tick();
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (c_done || d_done) nd++;
    end
    total++;
    if (nd != 0 || c_rdata !== 16'h0) begin
      bad++;
      $display("FAIL rmid_lost: dones=%0d c_rdata=%h, need 0 0000", nd, c_rdata);
    end
    d_req = 1; d_we = 1; d_adr = 16'h0500; d_wdata = 16'hA5A5;
    push(1'b1, 1'b1, 16'h0);
    tick();
    total++;
    if ({mem_write, mem_en, io_write} !== 3'b110 || mem_wdata !== 16'hA5A5) begin
      bad++;
      $display("FAIL rmid_next_access: wr/en/io=%b wdata=%h, need 110 a5a5", {mem_write, mem_en, io_write}, mem_wdata);
    end
    nd = 0;
    for (int i = 0; i < 6 && nd == 0; i++) begin
      tick();
      if (d_done) nd++;
    end
    d_req = 0;
    total++;
    if (nd != 1) begin
      bad++;
      $display("FAIL rmid_next_done: d_done seen %0d, need 1", nd);
    end
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_mem_read();
    test_io_write();
    test_round_robin();
    test_pulse();
    test_reset_mid();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: %0d outstanding, need 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
